// File: rtl/fifo_single_clk_pkg.sv
// fifo_single_clk_pkg: shared width derivations, parameter checks and
// operation encoding for the single-clock FIFO.
package fifo_single_clk_pkg;

   // Combined write/read acceptance of one cycle, {write, read}.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_RW   = 2'b11
   } fifo_op_e;

   // Pointer width; a one-bit pointer is kept even for tiny depths.
   function automatic int addr_w_f(input int depth);
      if (depth < 2) begin
         return 1;
      end else begin
         return $clog2(depth);
      end
   endfunction

   // Occupancy counter width: must represent 0..DEPTH inclusive.
   function automatic int cnt_w_f(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Legal parameter combination check, used at elaboration.
   function automatic bit params_ok_f(input int data_w, input int depth,
                                      input int afull_th, input int aempty_th);
      bit ok;
      ok = 1'b1;
      if (data_w < 1)                              ok = 1'b0;
      if (depth < 2)                               ok = 1'b0;
      if ((afull_th < 1) || (afull_th > depth))    ok = 1'b0;
      if ((aempty_th < 0) || (aempty_th > depth - 1)) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/fifo_single_clk_if.sv
// fifo_single_clk_if: producer/consumer-facing bus of the single-clock FIFO.
// master = the surrounding logic issuing requests, slave = the FIFO itself.
interface fifo_single_clk_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   import fifo_single_clk_pkg::*;

   localparam int CNT_W = cnt_w_f(DEPTH);

   logic              i_wInc;
   logic [DATA_W-1:0] i_wData;
   logic              i_rInc;
   logic              i_clrErr;
   logic [DATA_W-1:0] o_rData;
   logic              o_rValid;
   logic              o_empty;
   logic              o_full;
   logic              o_almostEmpty;
   logic              o_almostFull;
   logic [CNT_W-1:0]  o_count;
   logic              o_overflow;
   logic              o_underflow;

   modport master (
      output i_wInc, i_wData, i_rInc, i_clrErr,
      input  o_rData, o_rValid, o_empty, o_full, o_almostEmpty, o_almostFull,
             o_count, o_overflow, o_underflow
   );

   modport slave (
      input  i_wInc, i_wData, i_rInc, i_clrErr,
      output o_rData, o_rValid, o_empty, o_full, o_almostEmpty, o_almostFull,
             o_count, o_overflow, o_underflow
   );

endinterface

// File: rtl/fifo_single_clk_mem.sv
// fifo_single_clk_mem: DEPTH x DATA_W storage, synchronous write port and
// asynchronous read port. Contents are intentionally not reset.
module fifo_single_clk_mem
   import fifo_single_clk_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = addr_w_f(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_wAddr,
   input  logic [DATA_W-1:0] i_wData,
   input  logic [ADDR_W-1:0] i_rAddr,
   output logic [DATA_W-1:0] o_rData
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Store the accepted write word at the write pointer.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_wAddr] <= i_wData;
      end
   end

   assign o_rData = mem_q[i_rAddr];

endmodule

// File: rtl/fifo_single_clk.sv
// fifo_single_clk: single-clock FIFO of arbitrary DEPTH with occupancy
// count, almost-full/almost-empty thresholds and sticky overflow/underflow.
// Build option FIFO_SINGLE_CLK_FWFT_EN selects a first-word-fall-through
// read port; without it reads return data one cycle after acceptance.
module fifo_single_clk
   import fifo_single_clk_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = 12,
   parameter int AEMPTY_TH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   fifo_single_clk_if.slave  bus
);

   localparam int ADDR_W = addr_w_f(DEPTH);
   localparam int CNT_W  = cnt_w_f(DEPTH);

   localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  AFULL_CNT  = CNT_W'(AFULL_TH);
   localparam logic [CNT_W-1:0]  AEMPTY_CNT = CNT_W'(AEMPTY_TH);

   if (!params_ok_f(DATA_W, DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_param_err
      $error("fifo_single_clk: illegal DATA_W/DEPTH/AFULL_TH/AEMPTY_TH combination");
   end

   // Explicit wrap keeps non-power-of-two depths inside the array.
   function automatic logic [ADDR_W-1:0] ptr_inc_f(input logic [ADDR_W-1:0] ptr);
      if (ptr == LAST_PTR) begin
         return '0;
      end else begin
         return ptr + 1'b1;
      end
   endfunction

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              aempty_q, aempty_d;
   logic              afull_q, afull_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              w_acc_s;
   logic              r_acc_s;
   fifo_op_e          op_s;
   logic [DATA_W-1:0] mem_rdata_s;

   // Request acceptance, pointer/count advance and flag next-state.
   always_comb begin
      w_acc_s = bus.i_wInc & ~full_q;
      r_acc_s = bus.i_rInc & ~empty_q;
      op_s    = fifo_op_e'({w_acc_s, r_acc_s});

      if (w_acc_s) begin
         wptr_d = ptr_inc_f(wptr_q);
      end else begin
         wptr_d = wptr_q;
      end

      if (r_acc_s) begin
         rptr_d = ptr_inc_f(rptr_q);
      end else begin
         rptr_d = rptr_q;
      end

      case (op_s)
         OP_WR:   count_d = count_q + 1'b1;
         OP_RD:   count_d = count_q - 1'b1;
         OP_RW:   count_d = count_q;
         OP_IDLE: count_d = count_q;
         default: count_d = count_q;
      endcase

      // Flags follow the next count so they line up with o_count.
      empty_d  = (count_d == '0);
      full_d   = (count_d == FULL_CNT);
      aempty_d = (count_d <= AEMPTY_CNT);
      afull_d  = (count_d >= AFULL_CNT);

      // Error flags: a new error wins over a same-cycle clear.
      if (bus.i_wInc & full_q) begin
         ovf_d = 1'b1;
      end else if (bus.i_clrErr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      if (bus.i_rInc & empty_q) begin
         unf_d = 1'b1;
      end else if (bus.i_clrErr) begin
         unf_d = 1'b0;
      end else begin
         unf_d = unf_q;
      end
   end

   // Pointer, occupancy, flag and error state registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         aempty_q <= 1'b1;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         aempty_q <= aempty_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   fifo_single_clk_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (w_acc_s & ~i_rst),
      .i_wAddr (wptr_q),
      .i_wData (bus.i_wData),
      .i_rAddr (rptr_q),
      .o_rData (mem_rdata_s)
   );

   assign bus.o_empty       = empty_q;
   assign bus.o_full        = full_q;
   assign bus.o_almostEmpty = aempty_q;
   assign bus.o_almostFull  = afull_q;
   assign bus.o_count       = count_q;
   assign bus.o_overflow    = ovf_q;
   assign bus.o_underflow   = unf_q;

`ifdef FIFO_SINGLE_CLK_FWFT_EN
   // Head word is presented directly; i_rInc acknowledges it.
   assign bus.o_rData  = mem_rdata_s;
   assign bus.o_rValid = ~empty_q;
`else
   logic [DATA_W-1:0] rdata_q;
   logic              rvalid_q;

   // Capture the head word on an accepted read; valid pulses one cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= r_acc_s;
         if (r_acc_s) begin
            rdata_q <= mem_rdata_s;
         end
      end
   end

   assign bus.o_rData  = rdata_q;
   assign bus.o_rValid = rvalid_q;
`endif

endmodule

// File: tb/tb_fifo_single_clk.sv
// tb_fifo_single_clk: directed scenarios plus randomized traffic against a
// queue-based reference model; DEPTH=5, AFULL_TH=4, AEMPTY_TH=1.
module tb_fifo_single_clk;

   localparam int DATA_W    = 8;
   localparam int DEPTH     = 5;
   localparam int AFULL_TH  = 4;
   localparam int AEMPTY_TH = 1;

   logic clk;
   logic rst;

   fifo_single_clk_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   fifo_single_clk #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .AFULL_TH  (AFULL_TH),
      .AEMPTY_TH (AEMPTY_TH)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: FIFO contents as a queue plus error/read-port state.
   logic [7:0] mq [$];
   bit         m_ovf;
   bit         m_unf;
   bit         m_rv;
   logic [7:0] m_rd;
   bit         m_ok = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r_st, input bit w, input logic [7:0] d,
                             input bit r, input bit c);
      bit full, empty, wa, ra;
      if (r_st) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_rv  = 1'b0;
         m_rd  = 8'h00;
         m_ok  = 1'b1;
      end else begin
         full  = (mq.size() == DEPTH);
         empty = (mq.size() == 0);
         wa    = w && !full;
         ra    = r && !empty;
         if (w && full)       m_ovf = 1'b1;
         else if (c)          m_ovf = 1'b0;
         if (r && empty)      m_unf = 1'b1;
         else if (c)          m_unf = 1'b0;
         m_rv = ra;
         if (ra) begin
            m_rd = mq[0];
            void'(mq.pop_front());
         end
         if (wa) mq.push_back(d);
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, settle.
   task automatic tick(input bit r_st, input bit w, input logic [7:0] d,
                       input bit r, input bit c);
      rst          = r_st;
      bus.i_wInc   = w;
      bus.i_wData  = d;
      bus.i_rInc   = r;
      bus.i_clrErr = c;
      @(posedge clk);
      model_step(r_st, w, d, r, c);
      #1;
   endtask

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (m_ok) begin
         chk("cyc_count",  32'(bus.o_count),       32'(mq.size()));
         chk("cyc_empty",  32'(bus.o_empty),       32'(mq.size() == 0));
         chk("cyc_full",   32'(bus.o_full),        32'(mq.size() == DEPTH));
         chk("cyc_aempty", 32'(bus.o_almostEmpty), 32'(mq.size() <= AEMPTY_TH));
         chk("cyc_afull",  32'(bus.o_almostFull),  32'(mq.size() >= AFULL_TH));
         chk("cyc_ovf",    32'(bus.o_overflow),    32'(m_ovf));
         chk("cyc_unf",    32'(bus.o_underflow),   32'(m_unf));
`ifdef FIFO_SINGLE_CLK_FWFT_EN
         chk("cyc_rvalid", 32'(bus.o_rValid), 32'(mq.size() != 0));
         if (mq.size() != 0) chk("cyc_rdata", 32'(bus.o_rData), 32'(mq[0]));
`else
         chk("cyc_rvalid", 32'(bus.o_rValid), 32'(m_rv));
         chk("cyc_rdata",  32'(bus.o_rData),  32'(m_rd));
`endif
      end
   end

   bit exp_ae [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   bit exp_af [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   bit exp_fu [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      rst = 1'b0;
      bus.i_wInc = 1'b0; bus.i_wData = 8'h00; bus.i_rInc = 1'b0; bus.i_clrErr = 1'b0;
      @(negedge clk);

      // Reset state.
      tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("rst_count",  32'(bus.o_count), 32'd0);
      chk("rst_empty",  32'(bus.o_empty), 32'd1);
      chk("rst_full",   32'(bus.o_full), 32'd0);
      chk("rst_aempty", 32'(bus.o_almostEmpty), 32'd1);
      chk("rst_afull",  32'(bus.o_almostFull), 32'd0);
      chk("rst_err",    32'({bus.o_overflow, bus.o_underflow}), 32'd0);
      chk("rst_rvalid", 32'(bus.o_rValid), 32'd0);
`ifndef FIFO_SINGLE_CLK_FWFT_EN
      chk("rst_rdata",  32'(bus.o_rData), 32'd0);
`endif

      // Fill 0x11..0x15, thresholds crossed at 2, 4 and 5.
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
         chk("fill_count",  32'(bus.o_count), 32'(i + 1));
         chk("fill_aempty", 32'(bus.o_almostEmpty), 32'(exp_ae[i]));
         chk("fill_afull",  32'(bus.o_almostFull), 32'(exp_af[i]));
         chk("fill_full",   32'(bus.o_full), 32'(exp_fu[i]));
      end

      // Write while full is dropped and flagged.
      tick(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
      chk("ovf_flag",  32'(bus.o_overflow), 32'd1);
      chk("ovf_count", 32'(bus.o_count), 32'd5);

      // Drain in order.
      for (int i = 0; i < 5; i++) begin
`ifdef FIFO_SINGLE_CLK_FWFT_EN
         chk("drain_data", 32'(bus.o_rData), 32'(8'h11 + i));
         tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
`else
         tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         chk("drain_data",  32'(bus.o_rData), 32'(8'h11 + i));
         chk("drain_valid", 32'(bus.o_rValid), 32'd1);
`endif
      end
      chk("drain_empty",  32'(bus.o_empty), 32'd1);
      chk("ovf_sticky",   32'(bus.o_overflow), 32'd1);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_cleared",  32'(bus.o_overflow), 32'd0);

      // Count 2 with simultaneous write+read for 10 cycles; pointers wrap.
      tick(1'b0, 1'b1, 8'h21, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
         chk("rw_count", 32'(bus.o_count), 32'd2);
`ifndef FIFO_SINGLE_CLK_FWFT_EN
         chk("rw_data", 32'(bus.o_rData), (i < 2) ? 32'(8'h21 + i) : 32'(8'h30 + i - 2));
`endif
      end

      // Empty out, then underflow and error-clear behaviour.
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("unf_flag",   32'(bus.o_underflow), 32'd1);
      chk("unf_rvalid", 32'(bus.o_rValid), 32'd0);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_flags",  32'({bus.o_overflow, bus.o_underflow}), 32'd0);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_idle",   32'({bus.o_overflow, bus.o_underflow}), 32'd0);
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      chk("set_wins",   32'(bus.o_underflow), 32'd1);

      // Reset with requests pending at count 3.
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      tick(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
      chk("rst2_count",  32'(bus.o_count), 32'd0);
      chk("rst2_empty",  32'(bus.o_empty), 32'd1);
      chk("rst2_err",    32'({bus.o_overflow, bus.o_underflow}), 32'd0);
      chk("rst2_rvalid", 32'(bus.o_rValid), 32'd0);

      // Write-to-read latency into an empty FIFO.
      tick(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
`ifdef FIFO_SINGLE_CLK_FWFT_EN
      chk("lat_data",  32'(bus.o_rData), 32'h5A);
      chk("lat_valid", 32'(bus.o_rValid), 32'd1);
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
`else
      chk("lat_novalid", 32'(bus.o_rValid), 32'd0);
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("lat_data",  32'(bus.o_rData), 32'h5A);
      chk("lat_valid", 32'(bus.o_rValid), 32'd1);
`endif

      // Randomized traffic with phase-varying write/read bias.
      for (int blk = 0; blk < 15; blk++) begin
         int wp, rp;
         wp = $urandom_range(10, 90);
         rp = $urandom_range(10, 90);
         for (int i = 0; i < 200; i++) begin
            tick(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 99) < wp),
                 8'($urandom),
                 ($urandom_range(0, 99) < rp),
                 ($urandom_range(0, 19) == 0));
         end
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
